param_2to1_stream_arb: RTL and testbench
========================================

# param_2to1_stream_arb

Round-robin arbiter that shares one parameterized `nbits`-wide output channel between two val/rdy input streams. It drives the select of a 2-to-1 data mux and registers the selected message into a one-entry output buffer. It sits in front of any single-ported consumer that two producers must share, and sustains one transfer per cycle.

## Interface
- `nbits`, default 8, width of every message.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in0_val` input 1: stream 0 message valid.
- `in0_rdy` output 1: stream 0 accepted this cycle.
- `in0_msg` input `nbits`: stream 0 message.
- `in1_val` input 1: stream 1 message valid.
- `in1_rdy` output 1: stream 1 accepted this cycle.
- `in1_msg` input `nbits`: stream 1 message.
- `out_val` output 1: buffered message valid.
- `out_rdy` input 1: consumer accepts the buffered message.
- `out_msg` output `nbits`: buffered message.
- `out_src` output 1: input index (0/1) that supplied `out_msg`.

## Operation
- The output buffer FSM has two states, derived from `out_val`:
  - EMPTY→FULL on an input transfer.
  - FULL→EMPTY on an output transfer with no input transfer.
  - FULL→FULL on simultaneous output and input transfers, or when stalled.
- `can_accept = !out_val || out_rdy`. The buffer accepts when empty, or in the same cycle it drains.
- Priority register `prio` names the favoured input.
- Grant rules:
  - If both inputs are valid, `grant = prio`.
  - If only one is valid, it is granted.
  - If neither is valid, there is no grant.
- `ink_rdy = can_accept && grant==k`. At most one `rdy` is high per cycle.
- A `rdy` is never asserted to an input whose `val` is low.
- Input transfer when `ink_val && ink_rdy`. On that edge:
  - `out_msg <= ink_msg` (mux select = k).
  - `out_src <= k`, `out_val <= 1`.
  - `prio <= !k`.
- `prio` changes only on an input transfer. A stalled cycle leaves `prio` unchanged.
- Output transfer when `out_val && out_rdy`. If there is no input transfer in the same cycle, `out_val <= 0`.
- `out_msg` and `out_src` hold their value while `out_val` is low. They are not cleared when the buffer drains.
- While `out_val && !out_rdy`:
  - `out_msg` and `out_src` are stable.
  - Both `in*_rdy` are 0.
- No message is dropped or duplicated. Each accepted message appears exactly once on the output.

## Timing
- Reset values, applied immediately on assertion of `reset_n` low, independent of `clk`: `out_val=0`, `out_msg=0`, `out_src=0`, `prio=0`.
- Consequences of the reset values:
  - `in0_rdy` and `in1_rdy` are 0 unless the matching `val` is high.
  - With both valid on the first cycle after reset, in0 wins.
- Reset asserted mid-operation discards any buffered message and restores the reset values. Inputs not accepted before reset are not transferred.
- Latency: an input accepted at edge N is visible on `out_*` after edge N.
- Throughput: one message per cycle with `out_rdy` held high.
- Combinational paths:
  - Present: `out_rdy` → `in*_rdy` and `in*_val` → `in*_rdy`.
  - Absent: no combinational path from `in*_msg`, or from any input, to `out_*`.
- Fairness: with both inputs continuously valid and `out_rdy=1`, grants strictly alternate 0,1,0,1…

## Configuration
- Macro: `PARAM_2TO1_STREAM_ARB_FIXED_PRIO_EN`.
- Defined: `prio` is removed. in0 always wins when both inputs are valid. in1 is granted only when `in0_val=0`. All other behaviour and timing are unchanged.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset and basic transfer:
  - Assert `reset_n=0` mid-stream → `out_val=0`, `out_msg=0x00`, `out_src=0` without a clock edge.
  - Then release reset, `in0_val=1`, `in0_msg=0xA5`, `out_rdy=1` → next cycle `out_val=1`, `out_msg=0xA5`, `out_src=0`.
- Contention: both inputs valid for 4 cycles (in0=0x11, in1=0x22), `out_rdy=1` → outputs 0x11,0x22,0x11,0x22 on consecutive cycles with `out_src` 0,1,0,1.
  - With the macro defined → 0x11 on all four cycles and `in1_rdy` stays 0.
- Backpressure: buffer holds 0x33 with `out_rdy=0` for 3 cycles while in1 is valid with 0x44 → `out_msg` stays 0x33 and `in1_rdy=0`.
  - Raise `out_rdy` → `in1_rdy=1` in that same cycle, and 0x44 appears next cycle.
- Drain to empty: single message 0x55 accepted, then no valid inputs and `out_rdy=1` → `out_val` drops after one cycle, `out_msg` remains 0x55, and `prio` is unchanged.
- Single requester: only in1 valid while `prio=0`, 3 messages 0x01..0x03, `out_rdy=1` → all three accepted back-to-back in order with `out_src=1`.
- Random stress: random val/rdy on all ports for 1000 cycles with `nbits=16` → scoreboard shows no loss or duplication, per-input ordering is preserved, and no input waits more than one grant while the other input is being served.

Source files
------------

// File: rtl/param_2to1_stream_arb.sv
// ============================================================================
// Module   : param_2to1_stream_arb
// Brief    : Two-input val/rdy round-robin arbiter with a one-entry output buffer.
//            Define PARAM_2TO1_STREAM_ARB_FIXED_PRIO_EN for fixed in0-first priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_2to1_stream_arb #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in0_val,
   output logic             in0_rdy,
   input  logic [nbits-1:0] in0_msg,
   input  logic             in1_val,
   output logic             in1_rdy,
   input  logic [nbits-1:0] in1_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [nbits-1:0] out_msg,
   output logic             out_src
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   logic [nbits-1:0] r_msg;
   logic             r_src;

   logic             w_can_accept;
   logic             w_gnt_val;
   logic             w_gnt;
   logic             w_xfer_in;
   logic             w_xfer_out;

   assign w_can_accept = (r_state == ST_EMPTY) || out_rdy;
   assign w_gnt_val    = in0_val || in1_val;

`ifdef PARAM_2TO1_STREAM_ARB_FIXED_PRIO_EN
   assign w_gnt = !in0_val;
`else
   logic r_prio;

   // Contention resolves to the favoured input; a lone requester always wins.
   always_comb begin
      w_gnt = 1'b0;
      if (in0_val && in1_val)
         w_gnt = r_prio;
      else if (in1_val)
         w_gnt = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_prio <= 1'b0;
      else if (w_xfer_in)
         r_prio <= !w_gnt;
   end
`endif

   assign in0_rdy    = w_can_accept && w_gnt_val && !w_gnt;
   assign in1_rdy    = w_can_accept && w_gnt_val &&  w_gnt;
   assign w_xfer_in  = in0_rdy || in1_rdy;
   assign w_xfer_out = (r_state == ST_FULL) && out_rdy;

   // Buffer contents are only rewritten on an input transfer, so they persist after draining.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_EMPTY;
         r_msg   <= '0;
         r_src   <= 1'b0;
      end else if (w_xfer_in) begin
         r_state <= ST_FULL;
         r_msg   <= w_gnt ? in1_msg : in0_msg;
         r_src   <= w_gnt;
      end else if (w_xfer_out) begin
         r_state <= ST_EMPTY;
      end
   end

   assign out_val = (r_state == ST_FULL);
   assign out_msg = r_msg;
   assign out_src = r_src;

endmodule

`default_nettype wire

// File: tb/tb_param_2to1_stream_arb.sv
// ============================================================================
// Module   : tb_param_2to1_stream_arb
// Brief    : Directed and random-stress bench for param_2to1_stream_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_2to1_stream_arb;

`ifdef PARAM_2TO1_STREAM_ARB_FIXED_PRIO_EN
   localparam bit c_fixed = 1'b1;
`else
   localparam bit c_fixed = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       in0_val, in0_rdy, in1_val, in1_rdy;
   logic [7:0] in0_msg, in1_msg, out_msg;
   logic       out_val, out_rdy, out_src;

   logic        s_in0_val, s_in0_rdy, s_in1_val, s_in1_rdy;
   logic [15:0] s_in0_msg, s_in1_msg, s_out_msg;
   logic        s_out_val, s_out_rdy, s_out_src;

   int checks = 0;
   int errors = 0;

   param_2to1_stream_arb #(.nbits(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg),
      .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src)
   );

   param_2to1_stream_arb #(.nbits(16)) dut16 (
      .clk(clk), .reset_n(reset_n),
      .in0_val(s_in0_val), .in0_rdy(s_in0_rdy), .in0_msg(s_in0_msg),
      .in1_val(s_in1_val), .in1_rdy(s_in1_rdy), .in1_msg(s_in1_msg),
      .out_val(s_out_val), .out_rdy(s_out_rdy), .out_msg(s_out_msg), .out_src(s_out_src)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   logic [15:0] q[$];
   logic [15:0] exp16;
   logic [14:0] seq0, seq1;
   int          wait0, wait1, acc0, acc1;
   logic        a0, a1;

   initial begin
      reset_n = 1'b1;
      in0_val = 0; in1_val = 0; in0_msg = '0; in1_msg = '0; out_rdy = 0;
      s_in0_val = 0; s_in1_val = 0; s_in0_msg = '0; s_in1_msg = '0; s_out_rdy = 0;
      #1 reset_n = 1'b0;
      #1;
      check("rst_out_val", out_val, 0);
      check("rst_out_msg", out_msg, 0);
      check("rst_out_src", out_src, 0);
      check("rst_in0_rdy", in0_rdy, 0);
      check("rst_in1_rdy", in1_rdy, 0);
      tick(); tick();
      reset_n = 1'b1;

      // Load a message, drain it, load another, then reset asynchronously mid-cycle.
      in0_val = 1; in0_msg = 8'h77; out_rdy = 1;
      tick();
      check("pre_val", out_val, 1);
      check("pre_msg", out_msg, 8'h77);
      in0_val = 0;
      tick();
      check("pre_drain", out_val, 0);
      in0_val = 1; in0_msg = 8'h99;
      tick();
      check("pre2_msg", out_msg, 8'h99);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_val", out_val, 0);
      check("async_rst_msg", out_msg, 0);
      check("async_rst_src", out_src, 0);
      in0_val = 0;
      tick();
      reset_n = 1'b1;

      // Basic transfer
      in0_val = 1; in0_msg = 8'hA5; out_rdy = 1;
      #1;
      check("basic_in0_rdy", in0_rdy, 1);
      check("basic_in1_rdy", in1_rdy, 0);
      tick();
      check("basic_val", out_val, 1);
      check("basic_msg", out_msg, 8'hA5);
      check("basic_src", out_src, 0);
      in0_val = 0;
      tick();
      check("basic_drain", out_val, 0);
      pulse_reset();

      // Contention
      in0_val = 1; in0_msg = 8'h11; in1_val = 1; in1_msg = 8'h22; out_rdy = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("cont_val", out_val, 1);
         check("cont_msg", out_msg, (c_fixed || i % 2 == 0) ? 8'h11 : 8'h22);
         check("cont_src", out_src, (c_fixed || i % 2 == 0) ? 0 : 1);
         check("cont_in1_rdy", in1_rdy, (!c_fixed && i % 2 == 0) ? 1 : 0);
      end
      in0_val = 0; in1_val = 0;
      tick();
      check("cont_drain_val", out_val, 0);
      check("cont_drain_msg", out_msg, c_fixed ? 8'h11 : 8'h22);

      // Backpressure
      in0_val = 1; in0_msg = 8'h33;
      tick();
      check("bp_load", out_msg, 8'h33);
      in0_val = 0; in1_val = 1; in1_msg = 8'h44; out_rdy = 0;
      #1;
      check("bp_in1_rdy0", in1_rdy, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_val", out_val, 1);
         check("bp_hold_msg", out_msg, 8'h33);
         check("bp_hold_rdy", in1_rdy, 0);
      end
      out_rdy = 1;
      #1;
      check("bp_release_rdy", in1_rdy, 1);
      tick();
      check("bp_next_msg", out_msg, 8'h44);
      check("bp_next_src", out_src, 1);

      // Drain to empty; stall cycles must not move the priority
      in1_val = 0; in0_val = 1; in0_msg = 8'h55;
      #1;
      check("drain_in0_rdy", in0_rdy, 1);
      tick();
      check("drain_load", out_msg, 8'h55);
      in0_val = 0;
      tick();
      check("drain_val", out_val, 0);
      check("drain_msg", out_msg, 8'h55);
      check("drain_src", out_src, 0);
      tick();
      in0_val = 1; in0_msg = 8'h66; in1_val = 1; in1_msg = 8'h77;
      #1;
      check("prio_kept_in0", in0_rdy, c_fixed ? 1 : 0);
      check("prio_kept_in1", in1_rdy, c_fixed ? 0 : 1);
      in0_val = 0; in1_val = 0;
      pulse_reset();

      // Single requester on in1 with prio=0
      in1_val = 1;
      for (int k = 1; k <= 3; k++) begin
         in1_msg = 8'(k);
         #1;
         check("single_in1_rdy", in1_rdy, 1);
         check("single_in0_rdy", in0_rdy, 0);
         tick();
         check("single_val", out_val, 1);
         check("single_msg", out_msg, k);
         check("single_src", out_src, 1);
      end
      in1_val = 0;
      tick();
      check("single_drain", out_val, 0);

      // Random stress on the 16-bit instance; msg = {src, seq}
      pulse_reset();
      seq0 = '0; seq1 = '0; wait0 = 0; wait1 = 0; acc0 = 0; acc1 = 0;
      for (int cyc = 0; cyc < 1020; cyc++) begin
         if (cyc < 1000) begin
            if (!s_in0_val && $urandom_range(1, 0) == 1) begin
               s_in0_val = 1; s_in0_msg = {1'b0, seq0};
            end
            if (!s_in1_val && $urandom_range(1, 0) == 1) begin
               s_in1_val = 1; s_in1_msg = {1'b1, seq1};
            end
            s_out_rdy = ($urandom_range(3, 0) != 0);
         end else begin
            s_out_rdy = 1;
         end
         #4;
         a0 = s_in0_val && s_in0_rdy;
         a1 = s_in1_val && s_in1_rdy;
         if (s_in0_rdy && !s_in0_val) check("st_rdy0_noval", s_in0_rdy, 0);
         if (s_in1_rdy && !s_in1_val) check("st_rdy1_noval", s_in1_rdy, 0);
         if (s_in0_rdy && s_in1_rdy) check("st_both_rdy", 1, 0);
         if (s_out_val && s_out_rdy) begin
            check("st_q_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
               exp16 = q.pop_front();
               check("st_msg", s_out_msg, exp16);
               check("st_src", s_out_src, exp16[15]);
            end
         end
         if (a0) begin q.push_back(s_in0_msg); seq0++; acc0++; wait0 = 0; end
         if (a1) begin q.push_back(s_in1_msg); seq1++; acc1++; wait1 = 0; end
         if (s_in0_val && a1) wait0++;
         if (s_in1_val && a0 && c_fixed == 1'b0) wait1++;
         if (!c_fixed && (wait0 > 1 || wait1 > 1))
            check("st_fairness", (wait0 > wait1) ? wait0 : wait1, 1);
         tick();
         if (a0) s_in0_val = 0;
         if (a1) s_in1_val = 0;
      end
      check("st_all_out", q.size(), 0);
      check("st_out_empty", s_out_val, 0);
      check("st_in0_done", s_in0_val, 0);
      check("st_in1_done", s_in1_val, 0);
      check("st_traffic", (acc0 > 50 && acc1 > 50), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
